// File: rtl/alu_pkg.sv
// ALU opcodes, requester ids and result type shared by the ALU and its arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alu_pkg;

    // ALU operation encodings
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'h8;
    localparam logic [3:0] ALU_SLTU = 4'h9;
    localparam logic [3:0] ALU_BEQ  = 4'hA;
    localparam logic [3:0] ALU_BNE  = 4'hB;
    localparam logic [3:0] ALU_BLT  = 4'hC;
    localparam logic [3:0] ALU_BLTU = 4'hD;
    localparam logic [3:0] ALU_BGE  = 4'hE;
    localparam logic [3:0] ALU_BGEU = 4'hF;

    // Requester ids: pipeline EX stage and the auxiliary unit
    localparam logic REQ_EX  = 1'b0;
    localparam logic REQ_AUX = 1'b1;

    // One ALU operation as presented to the shared datapath
    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } alu_req_t;

    // One ALU result as held in a requester's result slot
    typedef struct packed {
        logic [31:0] c;
        logic        branch;
    } alu_res_t;

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit integer ALU with compare/branch evaluation.
// Latency: 0 cycles (combinational).
// Backpressure: none; the caller decides when the result is captured.
module alu
    import alu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] c,
    output logic        branch
);

    logic [4:0] shamt;
    logic       lt_s;
    logic       lt_u;
    logic       eq;

    assign shamt = b[4:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;
    assign eq    = a == b;

    // Evaluate the selected operation; branch ops report only the flag, C stays 0
    always_comb begin
        c      = 32'd0;
        branch = 1'b0;
        case (op)
            ALU_ADD:  c = a + b;
            ALU_SUB:  c = a - b;
            ALU_AND:  c = a & b;
            ALU_OR:   c = a | b;
            ALU_XOR:  c = a ^ b;
            ALU_SLL:  c = a << shamt;
            ALU_SRL:  c = a >> shamt;
            ALU_SRA:  c = 32'($signed(a) >>> shamt);
            ALU_SLT:  c = {31'd0, lt_s};
            ALU_SLTU: c = {31'd0, lt_u};
            ALU_BEQ:  branch = eq;
            ALU_BNE:  branch = !eq;
            ALU_BLT:  branch = lt_s;
            ALU_BLTU: branch = lt_u;
            ALU_BGE:  branch = !lt_s;
            ALU_BGEU: branch = !lt_u;
            default:  c = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between EX (port 0) and AUX (port 1); RR or fixed priority with starvation guard.
// Latency: 1 cycle from accept (valid&ready) to rsp_valid; 1 op/cycle aggregate throughput.
// Backpressure: a port is only accepted when its one-entry result slot is empty or draining.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int   PRIO_MODE  = 0,
    parameter int   STARVE_MAX = 8,
    parameter logic RR_INIT    = REQ_EX
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [3:0]  req_op0,
    input  logic [3:0]  req_op1,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_b1,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_c0,
    output logic [31:0] rsp_c1,
    output logic        rsp_br0,
    output logic        rsp_br1,
    output logic        grant_id,
    output logic [7:0]  starve_cnt
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    generate
        if (PRIO_MODE != 0 && PRIO_MODE != 1) begin : g_bad_prio
            $error("alu_share_arbiter: PRIO_MODE must be 0 or 1");
        end
        if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve
            $error("alu_share_arbiter: STARVE_MAX must be in 1..255");
        end
    endgenerate

    logic [1:0] slot_free;
    logic [1:0] eligible;
    logic       grant_vld;
    logic       grant_sel;
    logic       rr_ptr;
    logic       starve_hit;
    alu_req_t   alu_in;
    alu_res_t   alu_out;

    // A slot can take a new result if it is empty or being consumed this cycle.
    // Reset gates eligibility so nothing is accepted while the slots are held empty.
    assign slot_free  = ~rsp_valid | rsp_ready;
    assign eligible   = req_valid & slot_free & {2{rst_n}};
    assign grant_vld  = |eligible;
    assign starve_hit = (starve_cnt == STARVE_LIM);

    // Pick the winner among eligible ports; only contention needs a policy
    always_comb begin
        grant_sel = REQ_EX;
        if (&eligible) begin
            if (PRIO_MODE == 0) begin
                grant_sel = rr_ptr;
            end else begin
                grant_sel = starve_hit ? REQ_AUX : REQ_EX;
            end
        end else if (eligible[1]) begin
            grant_sel = REQ_AUX;
        end
    end

    assign req_ready[0] = grant_vld & (grant_sel == REQ_EX);
    assign req_ready[1] = grant_vld & (grant_sel == REQ_AUX);
    assign grant_id     = grant_vld & grant_sel;

    // Steer the granted port's operation into the shared ALU
    always_comb begin
        if (grant_sel == REQ_AUX) begin
            alu_in = '{op: req_op1, a: req_a1, b: req_b1};
        end else begin
            alu_in = '{op: req_op0, a: req_a0, b: req_b0};
        end
    end

    alu u_alu (
        .op     (alu_in.op),
        .a      (alu_in.a),
        .b      (alu_in.b),
        .c      (alu_out.c),
        .branch (alu_out.branch)
    );

    // Port 0 result slot: load on grant, otherwise drain when consumed, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid[0] <= 1'b0;
            rsp_c0       <= 32'd0;
            rsp_br0      <= 1'b0;
        end else if (req_ready[0]) begin
            rsp_valid[0] <= 1'b1;
            rsp_c0       <= alu_out.c;
            rsp_br0      <= alu_out.branch;
        end else if (rsp_ready[0]) begin
            rsp_valid[0] <= 1'b0;
        end
    end

    // Port 1 result slot: load on grant, otherwise drain when consumed, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid[1] <= 1'b0;
            rsp_c1       <= 32'd0;
            rsp_br1      <= 1'b0;
        end else if (req_ready[1]) begin
            rsp_valid[1] <= 1'b1;
            rsp_c1       <= alu_out.c;
            rsp_br1      <= alu_out.branch;
        end else if (rsp_ready[1]) begin
            rsp_valid[1] <= 1'b0;
        end
    end

    // Round-robin pointer hands priority to the other port after every grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= RR_INIT;
        end else if (grant_vld) begin
            rr_ptr <= ~grant_sel;
        end
    end

    // Count consecutive cycles port 1 waits while eligible; saturate rather than wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 8'd0;
        end else if (eligible[1] && !req_ready[1]) begin
            if (starve_cnt != 8'hFF) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end else begin
            starve_cnt <= 8'd0;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench with a result scoreboard for the shared-ALU arbiter (RR and fixed-priority instances).
// Latency: expects results one cycle after each observed accept.
// Backpressure: exercises held slots and same-cycle drain plus refill.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    // round-robin instance
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [3:0]  req_op0, req_op1;
    logic [31:0] req_a0, req_a1, req_b0, req_b1, rsp_c0, rsp_c1;
    logic        rsp_br0, rsp_br1, grant_id;
    logic [7:0]  starve_cnt;

    // fixed-priority instance
    logic [1:0]  fp_req_valid, fp_req_ready, fp_rsp_valid, fp_rsp_ready;
    logic [31:0] fp_rsp_c0, fp_rsp_c1;
    logic        fp_rsp_br0, fp_rsp_br1, fp_grant_id;
    logic [7:0]  fp_starve_cnt;

    alu_share_arbiter #(.PRIO_MODE(0), .STARVE_MAX(8), .RR_INIT(REQ_EX)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_c0(rsp_c0), .rsp_c1(rsp_c1), .rsp_br0(rsp_br0), .rsp_br1(rsp_br1),
        .grant_id(grant_id), .starve_cnt(starve_cnt)
    );

    alu_share_arbiter #(.PRIO_MODE(1), .STARVE_MAX(3), .RR_INIT(REQ_EX)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req_valid(fp_req_valid), .req_ready(fp_req_ready),
        .req_op0(ALU_ADD), .req_op1(ALU_ADD),
        .req_a0(32'd1), .req_a1(32'd2), .req_b0(32'd1), .req_b1(32'd2),
        .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready),
        .rsp_c0(fp_rsp_c0), .rsp_c1(fp_rsp_c1), .rsp_br0(fp_rsp_br0), .rsp_br1(fp_rsp_br1),
        .grant_id(fp_grant_id), .starve_cnt(fp_starve_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // expected {branch, c} per port, pushed when an accept is seen
    logic [32:0] exp0_q[$];
    logic [32:0] exp1_q[$];
    logic [31:0] exp_c0, exp_c1;
    logic        exp_br0, exp_br1;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        br;
    } vec_t;

    vec_t alu_vec [15];

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%09h expected 0x%09h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic br);
        req_op0 = op; req_a0 = a; req_b0 = b; exp_c0 = c; exp_br0 = br;
    endtask

    task automatic set1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic br);
        req_op1 = op; req_a1 = a; req_b1 = b; exp_c1 = c; exp_br1 = br;
    endtask

    // scoreboard monitor: check consumed results, then record newly accepted ops
    always @(negedge clk) begin : monitor
        logic [32:0] e;
        if (rst_n === 1'b1) begin
            if (rsp_valid[0] && rsp_ready[0]) begin
                if (exp0_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL sb_p0_unexpected: got 0x%08h with no result outstanding", rsp_c0);
                end else begin
                    e = exp0_q.pop_front();
                    chk("sb_p0", {rsp_br0, rsp_c0}, e);
                end
            end
            if (rsp_valid[1] && rsp_ready[1]) begin
                if (exp1_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL sb_p1_unexpected: got 0x%08h with no result outstanding", rsp_c1);
                end else begin
                    e = exp1_q.pop_front();
                    chk("sb_p1", {rsp_br1, rsp_c1}, e);
                end
            end
            if (req_valid[0] && req_ready[0]) exp0_q.push_back({exp_br0, exp_c0});
            if (req_valid[1] && req_ready[1]) exp1_q.push_back({exp_br1, exp_c1});
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    logic [1:0] rr_rdy [4];
    logic [7:0] fp_cnt [5];
    logic [1:0] fp_rdy [5];

    initial begin : stimulus
        alu_vec = '{
            '{ALU_ADD,  32'hFFFFFFFF, 32'd2,        32'h00000001, 1'b0},
            '{ALU_SUB,  32'd0,        32'd1,        32'hFFFFFFFF, 1'b0},
            '{ALU_AND,  32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0},
            '{ALU_OR,   32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0},
            '{ALU_XOR,  32'h12345678, 32'hFFFFFFFF, 32'hEDCBA987, 1'b0},
            '{ALU_SLL,  32'd1,        32'h00000025, 32'h00000020, 1'b0},
            '{ALU_SRL,  32'h80000000, 32'd31,       32'h00000001, 1'b0},
            '{ALU_SRA,  32'h80000010, 32'd2,        32'hE0000004, 1'b0},
            '{ALU_SLT,  32'hFFFFFFFE, 32'd1,        32'h00000001, 1'b0},
            '{ALU_SLTU, 32'hFFFFFFFE, 32'd1,        32'h00000000, 1'b0},
            '{ALU_BEQ,  32'd7,        32'd7,        32'h00000000, 1'b1},
            '{ALU_BNE,  32'd1,        32'd2,        32'h00000000, 1'b1},
            '{ALU_BGE,  32'd5,        32'd5,        32'h00000000, 1'b1},
            '{ALU_BGEU, 32'd1,        32'hFFFFFFFF, 32'h00000000, 1'b0},
            '{ALU_BGE,  32'h80000000, 32'd0,        32'h00000000, 1'b0}
        };
        rr_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
        fp_cnt = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
        fp_rdy = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01};

        rst_n = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        set0(ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0);
        set1(ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0);
        fp_req_valid = 2'b00;
        fp_rsp_ready = 2'b11;

        // reset state, with requests pending that must not be accepted
        @(negedge clk);
        chk("rst_rsp_valid", 33'(rsp_valid), 33'd0);
        chk("rst_rsp_c0", 33'(rsp_c0), 33'd0);
        chk("rst_rsp_c1", 33'(rsp_c1), 33'd0);
        chk("rst_rsp_br", 33'({rsp_br1, rsp_br0}), 33'd0);
        chk("rst_req_ready", 33'(req_ready), 33'd0);
        chk("rst_grant_id", 33'(grant_id), 33'd0);
        chk("rst_starve_cnt", 33'(starve_cnt), 33'd0);

        // single request on port 0
        step();
        rst_n = 1'b1;
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        set0(ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0);
        req_op1 = 'x; req_a1 = 'x; req_b1 = 'x;
        @(negedge clk);
        chk("single_req_ready", 33'(req_ready), 33'b01);
        chk("single_grant_id", 33'(grant_id), 33'd0);
        step();
        req_valid = 2'b00;
        @(negedge clk);
        chk("single_rsp_valid", 33'(rsp_valid), 33'b01);
        step();
        @(negedge clk);
        chk("single_drained", 33'(rsp_valid), 33'b00);

        // fresh reset so round-robin starts from its initial owner
        step(); rst_n = 1'b0;
        step(); rst_n = 1'b1;

        // round-robin contention: grants alternate 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            step();
            req_valid = 2'b11;
            if (k == 0) set0(ALU_ADD, 32'd10, 32'd20, 32'd30, 1'b0);
            if (k == 2) set0(ALU_XOR, 32'h0000F0F0, 32'h00000FF0, 32'h0000FF00, 1'b0);
            if (k < 2)  set1(ALU_SUB, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0);
            else        set1(ALU_SRA, 32'h80000000, 32'd4, 32'hF8000000, 1'b0);
            @(negedge clk);
            chk($sformatf("rr_req_ready_%0d", k), 33'(req_ready), 33'(rr_rdy[k]));
            chk($sformatf("rr_grant_id_%0d", k), 33'(grant_id), 33'(rr_rdy[k][1]));
        end
        step();
        req_valid = 2'b00;
        @(negedge clk);
        chk("rr_tail_rsp_valid", 33'(rsp_valid), 33'b10);

        // branch compares on port 1
        step();
        req_valid = 2'b10;
        set1(ALU_BLT, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);
        @(negedge clk);
        chk("blt_req_ready", 33'(req_ready), 33'b10);
        step();
        set1(ALU_BLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
        @(negedge clk);
        chk("bltu_req_ready", 33'(req_ready), 33'b10);
        step();
        req_valid = 2'b00;

        // back-to-back op table on port 0, port 1 inputs undriven
        req_op1 = 'x; req_a1 = 'x; req_b1 = 'x;
        for (int k = 0; k < 15; k++) begin
            step();
            req_valid = 2'b01;
            set0(alu_vec[k].op, alu_vec[k].a, alu_vec[k].b, alu_vec[k].c, alu_vec[k].br);
            @(negedge clk);
            chk($sformatf("ops_req_ready_%0d", k), 33'(req_ready), 33'b01);
        end
        step();
        req_valid = 2'b00;
        step();

        // back-pressure on port 0: slot holds, then drain and refill together
        rsp_ready = 2'b10;
        set0(ALU_ADD, 32'd1, 32'd1, 32'd2, 1'b0);
        req_valid = 2'b01;
        @(negedge clk);
        chk("bp_first_accept", 33'(req_ready), 33'b01);
        step();
        set0(ALU_ADD, 32'd3, 32'd3, 32'd6, 1'b0);
        @(negedge clk);
        chk("bp_blocked_0", 33'(req_ready), 33'b00);
        chk("bp_hold_c0_0", 33'(rsp_c0), 33'd2);
        step();
        @(negedge clk);
        chk("bp_blocked_1", 33'(req_ready), 33'b00);
        chk("bp_hold_c0_1", 33'(rsp_c0), 33'd2);
        step();
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("bp_drain_refill", 33'(req_ready), 33'b01);
        step();
        req_valid = 2'b00;
        @(negedge clk);
        chk("bp_refilled_valid", 33'(rsp_valid), 33'b01);
        chk("bp_refilled_c0", 33'(rsp_c0), 33'd6);
        step();
        @(negedge clk);
        chk("bp_empty", 33'(rsp_valid), 33'b00);

        // fill both slots (last grant was port 0, so port 1 goes first)
        step();
        rsp_ready = 2'b00;
        req_valid = 2'b11;
        set0(ALU_ADD, 32'd100, 32'd1, 32'd101, 1'b0);
        set1(ALU_ADD, 32'd200, 32'd2, 32'd202, 1'b0);
        @(negedge clk);
        chk("fill_grant_p1", 33'(req_ready), 33'b10);
        step();
        @(negedge clk);
        chk("fill_grant_p0", 33'(req_ready), 33'b01);
        step();
        req_valid = 2'b00;
        @(negedge clk);
        chk("fill_rsp_valid", 33'(rsp_valid), 33'b11);
        chk("fill_c0", 33'(rsp_c0), 33'd101);
        chk("fill_c1", 33'(rsp_c1), 33'd202);

        // asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", 33'(rsp_valid), 33'b00);
        chk("arst_c0", 33'(rsp_c0), 33'd0);
        chk("arst_c1", 33'(rsp_c1), 33'd0);
        exp0_q.delete();
        exp1_q.delete();
        step();
        rst_n = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        set0(ALU_SUB, 32'd9, 32'd4, 32'd5, 1'b0);
        set1(ALU_OR, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0);
        @(negedge clk);
        chk("arst_rr_init", 33'(req_ready), 33'b01);
        step();
        @(negedge clk);
        chk("arst_rr_next", 33'(req_ready), 33'b10);
        step();
        req_valid = 2'b00;
        step();

        // fixed priority with starvation guard at 3
        fp_req_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("fp_starve_cnt_%0d", k), 33'(fp_starve_cnt), 33'(fp_cnt[k]));
            chk($sformatf("fp_req_ready_%0d", k), 33'(fp_req_ready), 33'(fp_rdy[k]));
            if (k == 4) begin
                chk("fp_rsp_valid", 33'(fp_rsp_valid), 33'b10);
                chk("fp_rsp_c1", 33'(fp_rsp_c1), 33'd4);
            end
            step();
        end
        fp_req_valid = 2'b00;
        step();
        @(negedge clk);

        chk("sb_p0_drained", 33'(exp0_q.size()), 33'd0);
        chk("sb_p1_drained", 33'(exp1_q.size()), 33'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
